// File: rtl/shift_pkg.sv
// shift_pkg: op codes, op type and op helpers shared by the shift pipeline
package shift_pkg;
  typedef logic [2:0] op_t;
  localparam op_t OP_SLL = 3'b000;
  localparam op_t OP_SRL = 3'b001;
  localparam op_t OP_SRA = 3'b010;
  localparam op_t OP_ROL = 3'b011;
  localparam op_t OP_ROR = 3'b100;
  function automatic logic is_legal_op(op_t op);
    return op <= OP_ROR;
  endfunction
  // Ops that run through the left-shift core in bit-reversed form
  function automatic logic is_rev_op(op_t op);
    return op == OP_SRL || op == OP_SRA || op == OP_ROR;
  endfunction
endpackage

// File: rtl/shift_stage.sv
// shift_stage: one left-shift level (2^K) with its pipeline register and valid/ready
// Ports: in_* from the previous level (valid, ready, data, amt, op, tag, err, sign),
// out_* registered toward the next level; out_ready is the next level's in_ready.
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  parameter int K = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_amt,
  input  op_t                      in_op,
  input  logic [TAG_W-1:0]         in_tag,
  input  logic                     in_err,
  input  logic                     in_sign,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(WIDTH)-1:0] out_amt,
  output op_t                      out_op,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_err,
  output logic                     out_sign
);
  localparam int SHW = $clog2(WIDTH);
  localparam int S = 1 << K;
  localparam bit LAST = (K == SHW - 1);
  logic [S-1:0] fill;
  logic [WIDTH-1:0] shifted, rev, res;
  // Rotates wrap the top bits; SRA (already reversed) fills with the latched sign
  always_comb begin
    fill = (in_op == OP_ROL || in_op == OP_ROR) ? in_data[WIDTH-1 -: S]
                                                : {S{in_op == OP_SRA && in_sign}};
    shifted = in_amt[K] ? {in_data[WIDTH-1-S:0], fill} : in_data;
    for (int i = 0; i < WIDTH; i++) rev[i] = shifted[WIDTH-1-i];
    // The last level undoes the input reversal so the output port stays registered
    res = (LAST && is_rev_op(in_op)) ? rev : shifted;
  end
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_amt   <= '0;
      out_op    <= OP_SLL;
      out_tag   <= '0;
      out_err   <= 1'b0;
      out_sign  <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= res;
        out_amt  <= in_amt;
        out_op   <= in_op;
        out_tag  <= in_tag;
        out_err  <= in_err;
        out_sign <= in_sign;
      end
    end
  end
endmodule

// File: rtl/shift_pipe.sv
// shift_pipe: pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR), one shift level per stage
// Ports: in_valid/in_ready/in_data/in_amt/in_op/in_tag accept an operation;
// out_valid/out_ready/out_data/out_tag/out_err deliver results in acceptance order.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_amt,
  input  op_t                      in_op,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_err
);
  localparam int SHW = $clog2(WIDTH);
  logic             valid [SHW+1];
  logic             rdy   [SHW+1];
  logic [WIDTH-1:0] data  [SHW+1];
  logic [SHW-1:0]   amt   [SHW+1];
  op_t              op    [SHW+1];
  logic [TAG_W-1:0] tag   [SHW+1];
  logic             err   [SHW+1];
  logic             sign  [SHW+1];
  logic [WIDTH-1:0] rev_in;
  logic             unused_tail;
  always_comb begin
    for (int i = 0; i < WIDTH; i++) rev_in[i] = in_data[WIDTH-1-i];
  end
  // Illegal ops pass through unshifted by forcing a zero amount
  assign valid[0] = in_valid;
  assign data[0]  = is_rev_op(in_op) ? rev_in : in_data;
  assign amt[0]   = is_legal_op(in_op) ? in_amt : '0;
  assign op[0]    = in_op;
  assign tag[0]   = in_tag;
  assign err[0]   = !is_legal_op(in_op);
  assign sign[0]  = in_data[WIDTH-1];
  assign rdy[SHW] = out_ready;
  assign in_ready = rdy[0];
  genvar k;
  generate
    for (k = 0; k < SHW; k++) begin : g_stage
      shift_stage #(.WIDTH(WIDTH), .TAG_W(TAG_W), .K(k)) u_stage (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(valid[k]),
        .in_ready(rdy[k]),
        .in_data(data[k]),
        .in_amt(amt[k]),
        .in_op(op[k]),
        .in_tag(tag[k]),
        .in_err(err[k]),
        .in_sign(sign[k]),
        .out_valid(valid[k+1]),
        .out_ready(rdy[k+1]),
        .out_data(data[k+1]),
        .out_amt(amt[k+1]),
        .out_op(op[k+1]),
        .out_tag(tag[k+1]),
        .out_err(err[k+1]),
        .out_sign(sign[k+1])
      );
    end
  endgenerate
  assign out_valid   = valid[SHW];
  assign out_data    = data[SHW];
  assign out_tag     = tag[SHW];
  assign out_err     = err[SHW];
  assign unused_tail = ^{amt[SHW], op[SHW], sign[SHW]};
endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: directed and random checks of shift_pipe against an arithmetic reference model
module tb_shift_pipe;
  localparam int WIDTH = 32;
  localparam int TAG_W = 4;
  localparam int SHW = 5;
  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic [TAG_W-1:0] t;
    logic             e;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic [SHW-1:0] in_amt = '0;
  logic [2:0] in_op = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic out_err;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t q[$];
  logic held = 1'b0;
  exp_t hold_v;
  always #5 clk = ~clk;
  shift_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_err(out_err)
  );
  function automatic exp_t model(logic [2:0] op, logic [WIDTH-1:0] d, logic [SHW-1:0] a, logic [TAG_W-1:0] t);
    exp_t r;
    logic [2*WIDTH-1:0] dd;
    dd = {d, d} << a;
    r.t = t;
    r.e = 1'b0;
    case (op)
      3'd0: r.d = d << a;
      3'd1: r.d = d >> a;
      3'd2: r.d = $signed(d) >>> a;
      3'd3: r.d = dd[2*WIDTH-1:WIDTH];
      3'd4: begin dd = {d, d} >> a; r.d = dd[WIDTH-1:0]; end
      default: begin r.d = d; r.e = 1'b1; end
    endcase
    return r;
  endfunction
  task automatic drive(logic v, logic [2:0] op, logic [WIDTH-1:0] d, logic [SHW-1:0] a, logic [TAG_W-1:0] t);
    in_valid = v; in_op = op; in_data = d; in_amt = a; in_tag = t;
  endtask
  // One clock: check handshake/output against the model, then advance to the next negedge
  task automatic tick();
    exp_t e;
    #1;
    checks++;
    assert (in_ready === (q.size() < SHW || out_ready))
      else begin errors++; $error("FAIL in_ready obs %b exp %b occ %0d", in_ready, (q.size() < SHW || out_ready), q.size()); end
    if (held) begin
      checks++;
      assert ({out_data, out_tag, out_err} === hold_v)
        else begin errors++; $error("FAIL stall_hold obs %h exp %h", {out_data, out_tag, out_err}, hold_v); end
    end
    if (out_valid) begin
      checks++;
      assert (q.size() > 0)
        else begin errors++; $error("FAIL spurious_out obs valid=1 exp valid=0 data %h", out_data); end
      if (q.size() > 0 && out_ready) begin
        e = q.pop_front();
        checks++;
        assert ({out_data, out_tag, out_err} === e)
          else begin errors++; $error("FAIL result obs d=%h t=%h e=%b exp d=%h t=%h e=%b", out_data, out_tag, out_err, e.d, e.t, e.e); end
      end
    end
    held = out_valid && !out_ready;
    hold_v = {out_data, out_tag, out_err};
    if (in_valid && in_ready) q.push_back(model(in_op, in_data, in_amt, in_tag));
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask
  task automatic single(string name, logic [2:0] op, logic [WIDTH-1:0] d, logic [SHW-1:0] a, logic [WIDTH-1:0] xd, logic xe);
    int n;
    out_ready = 1'b1;
    drive(1'b1, op, d, a, 4'h5);
    tick();
    drive(1'b0, 3'd0, '0, '0, '0);
    n = 1;
    while (!out_valid && n < 20) begin tick(); n++; end
    checks++;
    assert (n === SHW) else begin errors++; $error("FAIL %s_latency obs %0d exp %0d", name, n, SHW); end
    checks++;
    assert (out_data === xd && out_err === xe)
      else begin errors++; $error("FAIL %s obs d=%h e=%b exp d=%h e=%b", name, out_data, out_err, xd, xe); end
    tick();
  endtask
  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    drive(1'b0, 3'd0, '0, '0, '0);
    while (q.size() > 0 && n < 100) begin tick(); n++; end
    checks++;
    assert (q.size() === 0) else begin errors++; $error("FAIL drain obs %0d left exp 0", q.size()); end
  endtask
  initial begin
    int i;
    int budget;
    logic [3:0] pat;
    logic [2:0] op;
    pat = 4'b1001;
    @(negedge clk);
    #1;
    checks++;
    assert (out_valid === 1'b0 && out_data === '0 && out_tag === '0 && out_err === 1'b0)
      else begin errors++; $error("FAIL reset_out obs v=%b d=%h t=%h e=%b exp 0", out_valid, out_data, out_tag, out_err); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    assert (in_ready === 1'b1) else begin errors++; $error("FAIL reset_in_ready obs %b exp 1", in_ready); end
    single("sll31", 3'd0, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0);
    single("sra4", 3'd2, 32'h8000_00F0, 5'd4, 32'hF800_000F, 1'b0);
    single("srl4", 3'd1, 32'h8000_00F0, 5'd4, 32'h0800_000F, 1'b0);
    single("ror8", 3'd4, 32'h1234_5678, 5'd8, 32'h7812_3456, 1'b0);
    single("rol0", 3'd3, 32'h1234_5678, 5'd0, 32'h1234_5678, 1'b0);
    single("rol4", 3'd3, 32'h1234_5678, 5'd4, 32'h2345_6781, 1'b0);
    single("illegal", 3'd6, 32'hDEAD_BEEF, 5'd7, 32'hDEAD_BEEF, 1'b1);
    single("after_illegal", 3'd0, 32'hDEAD_BEEF, 5'd4, 32'hEADB_EEF0, 1'b0);
    // 20-op stream under 1,0,0,1 backpressure
    i = 0;
    budget = cyc + 400;
    while (i < 20 && cyc < budget) begin
      out_ready = pat[cyc % 4];
      drive(1'b1, 3'($urandom_range(0, 4)), $urandom, 5'($urandom_range(0, 31)), 4'(i));
      #1;
      if (in_ready) i++;
      tick();
    end
    checks++;
    assert (i === 20) else begin errors++; $error("FAIL stream_accept obs %0d exp 20", i); end
    drain();
    // random traffic
    for (int n = 0; n < 400; n++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      drive($urandom_range(0, 3) != 0, op, $urandom, 5'($urandom_range(0, 31)), 4'($urandom));
      tick();
    end
    drain();
    // reset with ops in flight
    out_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      drive(1'b1, 3'd3, $urandom, 5'($urandom_range(1, 31)), 4'(n));
      tick();
    end
    drive(1'b0, 3'd0, '0, '0, '0);
    rst_n = 1'b0;
    #1;
    checks++;
    assert (out_valid === 1'b0 && out_data === '0)
      else begin errors++; $error("FAIL midreset obs v=%b d=%h exp v=0 d=0", out_valid, out_data); end
    q.delete();
    held = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    assert (in_ready === 1'b1) else begin errors++; $error("FAIL release_in_ready obs %b exp 1", in_ready); end
    for (int n = 0; n < 10; n++) tick();
    single("post_reset", 3'd1, 32'hF000_0000, 5'd28, 32'h0000_000F, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
